// File: rtl/alu_serie.sv
// Bit-serial N-bit ALU: one 1-bit add/logic slice, LSB first, registered carry between slices.
// Optional ALU_SERIE_OVF_EN adds a signed-overflow output loaded alongside c_out.
module alu_serie #(
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         arit,
   input  logic [1:0]   s,
   input  logic         c_in,
   output logic         busy,
   output logic         done,
   output logic [N-1:0] result,
   output logic         c_out
`ifdef ALU_SERIE_OVF_EN
   ,
   output logic         ovf
`endif
);

   localparam int CW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   // Handshake: start is sampled only in IDLE; busy is high while in RUN;
   // done is a one-cycle pulse in DONE, when result/c_out have just been loaded.
   state_t        state_q, state_d;
   logic [N-1:0]  sh_a, sh_b, acc, acc_next;
   logic          arit_q;
   logic [1:0]    s_q;
   logic          carry_q, carry_next, slice, b_eff;
   logic [CW-1:0] cnt;
   logic          last_bit;

   assign last_bit = (cnt == CW'(N - 1));
   assign busy     = (state_q == RUN);
   assign done     = (state_q == DONE);

   // The 1-bit cell; logic ops never propagate a carry.
   always_comb begin
      slice      = 1'b0;
      carry_next = 1'b0;
      b_eff      = (arit_q & s_q[0]) ? ~sh_b[0] : sh_b[0];
      if (arit_q) begin
         slice      = sh_a[0] ^ b_eff ^ carry_q;
         carry_next = (sh_a[0] & b_eff) | (sh_a[0] & carry_q) | (b_eff & carry_q);
      end else begin
         case (s_q)
            2'b00:   slice = sh_a[0] & sh_b[0];
            2'b01:   slice = sh_a[0] | sh_b[0];
            2'b10:   slice = sh_a[0] ^ sh_b[0];
            default: slice = ~sh_a[0];
         endcase
      end
   end

   generate
      if (N == 1) begin : g_acc1
         assign acc_next = slice;
      end else begin : g_accn
         assign acc_next = {slice, acc[N-1:1]};
      end
   endgenerate

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = RUN;
         RUN:     if (last_bit) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sh_a    <= '0;
         sh_b    <= '0;
         acc     <= '0;
         arit_q  <= 1'b0;
         s_q     <= 2'b00;
         carry_q <= 1'b0;
         cnt     <= '0;
         result  <= '0;
         c_out   <= 1'b0;
`ifdef ALU_SERIE_OVF_EN
         ovf     <= 1'b0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  sh_a    <= a;
                  sh_b    <= b;
                  arit_q  <= arit;
                  s_q     <= s;
                  carry_q <= arit & c_in;
                  cnt     <= '0;
               end
            end
            RUN: begin
               sh_a    <= sh_a >> 1;
               sh_b    <= sh_b >> 1;
               acc     <= acc_next;
               carry_q <= carry_next;
               cnt     <= cnt + 1'b1;
               if (last_bit) begin
                  result <= acc_next;
                  c_out  <= carry_next;
`ifdef ALU_SERIE_OVF_EN
                  // carry_q here is the carry into bit N-1
                  ovf    <= arit_q & (carry_q ^ carry_next);
`endif
               end
            end
            default: ;
         endcase
      end
   end

endmodule
